// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-outstanding APB3 initiator that bridges core req/gnt/rvalid
// transactions onto an APB peripheral bus, with PREADY wait states and a stall timeout.
module apb_cfg_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic [1:0]                fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        timeout_hit;
    logic        unused_addr_bits;

    // Handshake: req_i/gnt_o accept a transfer on a rising edge where both are high;
    // every accepted transfer yields exactly one rvalid_o pulse, with rdata_o/err_o.
    assign gnt_o     = (state == IDLE) && req_i;
    assign PSEL      = (state != IDLE);
    assign PENABLE   = (state == ACCESS);
    assign fsm_state = state;

    assign unused_addr_bits = ^addr_i[1:0];

    // wait_cnt holds the number of PREADY-low access cycles already seen, so the
    // current low cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            wait_cnt <= 16'h0000;
            PADDR    <= '0;
            PWDATA   <= 32'h0000_0000;
            PWRITE   <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0000_0000;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0000_0000;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        PADDR  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                        PWRITE <= we_i;
                        PWDATA <= wdata_i;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= 16'h0000;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rvalid_o <= 1'b1;
                        rdata_o  <= PWRITE ? 32'h0000_0000 : PRDATA;
                        err_o    <= PSLVERR;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        rvalid_o <= 1'b1;
                        err_o    <= 1'b1;
                        state    <= IDLE;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'h0001;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench for apb_cfg_master: directed and randomized APB transfers
// checked cycle by cycle against a transaction-level reference model.
module tb_apb_cfg_master;

    localparam int TO = 4;

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // main instance (timeout 4)
    logic        req = 1'b0;
    logic [11:0] addr_in = '0;
    logic        we_in = 1'b0;
    logic [31:0] wdata_in = '0;
    logic        gnt, rvalid, err, pwrite, psel, penable;
    logic [31:0] rdata, pwdata;
    logic [11:0] paddr;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [1:0]  st;

    // second instance (timeout disabled)
    logic        req0 = 1'b0;
    logic        gnt0, rvalid0, err0, pwrite0, psel0, penable0;
    logic [31:0] rdata0, pwdata0;
    logic [11:0] paddr0;
    logic [31:0] prdata0 = '0;
    logic        pready0 = 1'b0;
    logic [1:0]  st0;

    logic        junk_err = 1'b0;
    logic [32:0] exp_q[$];

    apb_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) u_dut (
        .HCLK(clk), .HRESET(rst), .req_i(req), .addr_i(addr_in), .we_i(we_in),
        .wdata_i(wdata_in), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .fsm_state(st)
    );

    apb_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .req_i(req0), .addr_i(12'h044), .we_i(1'b0),
        .wdata_i(32'h0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
        .PADDR(paddr0), .PWDATA(pwdata0), .PWRITE(pwrite0), .PSEL(psel0), .PENABLE(penable0),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(1'b0), .fsm_state(st0)
    );

    // clock/reset block
    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: result of one transfer is {err, rdata}
    function automatic logic [32:0] model(input logic we, input int waits,
                                          input logic [31:0] prd, input logic serr);
        if (TO != 0 && waits >= TO) return {1'b1, 32'h0};
        return {serr, (we ? 32'h0 : prd)};
    endfunction

    function automatic int n_access(input int waits);
        if (TO != 0 && waits >= TO) return TO;
        return waits + 1;
    endfunction

    // Called on a falling edge where the DUT is in IDLE; returns on the rvalid cycle.
    task automatic xfer(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] prd, input logic serr,
                        input logic hold);
        logic [11:0] exp_addr;
        logic [32:0] exp;
        int n;
        exp_addr = {addr[11:2], 2'b00};
        n = n_access(waits);
        exp_q.push_back(model(we, waits, prd, serr));
        req = 1'b1; addr_in = addr; we_in = we; wdata_in = wd;
        #1;
        chk("gnt_idle", {31'b0, gnt}, 32'd1);
        @(negedge clk);
        req = hold; addr_in = 12'($urandom); we_in = 1'($urandom); wdata_in = $urandom;
        #1;
        chk("gnt_setup", {31'b0, gnt}, 32'd0);
        chk("psel_setup", {31'b0, psel}, 32'd1);
        chk("penable_setup", {31'b0, penable}, 32'd0);
        chk("paddr_setup", {20'b0, paddr}, {20'b0, exp_addr});
        chk("pwrite_setup", {31'b0, pwrite}, {31'b0, we});
        chk("pwdata_setup", pwdata, wd);
        chk("rvalid_setup", {31'b0, rvalid}, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("psel_access", {31'b0, psel}, 32'd1);
            chk("penable_access", {31'b0, penable}, 32'd1);
            chk("paddr_access", {20'b0, paddr}, {20'b0, exp_addr});
            chk("pwrite_access", {31'b0, pwrite}, {31'b0, we});
            chk("pwdata_access", pwdata, wd);
            chk("gnt_access", {31'b0, gnt}, 32'd0);
            chk("rvalid_access", {31'b0, rvalid}, 32'd0);
            chk("rdata_idle", rdata, 32'd0);
            chk("err_idle", {31'b0, err}, 32'd0);
            if (i == waits) begin
                pready = 1'b1; prdata = prd; pslverr = serr;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = junk_err ? 1'b1 : 1'($urandom);
            end
        end
        @(negedge clk);
        #1;
        exp = exp_q.pop_front();
        chk("rvalid_done", {31'b0, rvalid}, 32'd1);
        chk("rdata_done", rdata, exp[31:0]);
        chk("err_done", {31'b0, err}, {31'b0, exp[32]});
        chk("psel_done", {31'b0, psel}, 32'd0);
        chk("penable_done", {31'b0, penable}, 32'd0);
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        #1;
        chk("rvalid_gap", {31'b0, rvalid}, 32'd0);
        chk("psel_gap", {31'b0, psel}, 32'd0);
        chk("rdata_gap", rdata, 32'd0);
        chk("err_gap", {31'b0, err}, 32'd0);
    endtask

    initial begin
        logic hold;
        logic prev_hold;
        // reset state, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_paddr", {20'b0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed: plain write, waited read, slave error, error ignored while waiting
        xfer(1'b1, 12'h008, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0);
        idle_cycle();
        xfer(1'b0, 12'h013, 32'h0, 3, 32'h0000_8082, 1'b0, 1'b0);
        idle_cycle();
        xfer(1'b1, 12'h104, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle_cycle();
        junk_err = 1'b1;
        xfer(1'b1, 12'h108, 32'hA5A5_0002, 2, 32'h0, 1'b0, 1'b0);
        junk_err = 1'b0;
        idle_cycle();
        // timeout abort
        xfer(1'b0, 12'h020, 32'h0, 10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle_cycle();
        // back-to-back reads with req held
        xfer(1'b0, 12'h030, 32'h0, 0, 32'h1111_1111, 1'b0, 1'b1);
        xfer(1'b0, 12'h034, 32'h0, 0, 32'h2222_2222, 1'b0, 1'b0);
        idle_cycle();

        // randomized transfers
        prev_hold = 1'b0;
        for (int t = 0; t < 40; t++) begin
            hold = (t != 39) && ($urandom_range(0, 3) == 0);
            xfer(1'($urandom), 12'($urandom), $urandom, $urandom_range(0, 6),
                 $urandom, 1'($urandom), hold);
            prev_hold = hold;
            if (!prev_hold) idle_cycle();
        end

        // reset in the middle of an access phase
        req = 1'b1; addr_in = 12'h050; we_in = 1'b0;
        #1;
        chk("gnt_pre_rst", {31'b0, gnt}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        pready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_psel", {31'b0, psel}, 32'd0);
        chk("midrst_penable", {31'b0, penable}, 32'd0);
        chk("midrst_paddr", {20'b0, paddr}, 32'd0);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pready = 1'b1; prdata = 32'h5555_AAAA;
        idle_cycle();
        idle_cycle();
        pready = 1'b0;
        xfer(1'b0, 12'h060, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
        idle_cycle();

        // timeout disabled: no abort during a long stall
        req0 = 1'b1;
        #1;
        chk("gnt0", {31'b0, gnt0}, 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        #1;
        chk("psel0_setup", {31'b0, psel0}, 32'd1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            chk("rvalid0_stall", {31'b0, rvalid0}, 32'd0);
            chk("penable0_stall", {31'b0, penable0}, 32'd1);
        end
        pready0 = 1'b1; prdata0 = 32'hCAFE_0001;
        @(negedge clk);
        #1;
        chk("rvalid0_done", {31'b0, rvalid0}, 32'd1);
        chk("rdata0_done", rdata0, 32'hCAFE_0001);
        chk("err0_done", {31'b0, err0}, 32'd0);
        pready0 = 1'b0;

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
